// File: rtl/gcm_block_packer_pkg.sv
// Shared types and helpers for the GCM block packer feeding aes_api.
package aes_gcm_pkg;

    localparam int unsigned BLK_BYTES  = 16;
    localparam int unsigned BEAT_BYTES = 4;

    typedef enum logic [1:0] {FILL, EMIT, GAP, LENB} pack_state_t;

    // Low n bits set: byte lanes 0..n-1 carry message data.
    function automatic logic [BLK_BYTES-1:0] byte_mask_from_count(input logic [4:0] n);
        logic [BLK_BYTES-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < BLK_BYTES; k++) begin
            if (5'(k) < n) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [2:0] keep_count(input logic [BEAT_BYTES-1:0] keep);
        return {2'b00, keep[0]} + {2'b00, keep[1]} + {2'b00, keep[2]} + {2'b00, keep[3]};
    endfunction

endpackage

// File: rtl/gcm_block_packer.sv
// Packs a 32-bit byte stream into zero-padded 128-bit aes_api blocks.
// Define GCM_PACK_LEN_BLOCK_EN to append the GHASH length block after each message.
module gcm_block_packer
    import aes_gcm_pkg::pack_state_t;
    import aes_gcm_pkg::FILL;
    import aes_gcm_pkg::EMIT;
    import aes_gcm_pkg::LENB;
    import aes_gcm_pkg::BLK_BYTES;
    import aes_gcm_pkg::BEAT_BYTES;
    import aes_gcm_pkg::byte_mask_from_count;
    import aes_gcm_pkg::keep_count;
#(
    parameter int unsigned GAP   = 1,
    parameter int unsigned LEN_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [8*BEAT_BYTES-1:0]   s_data,
    input  logic [BEAT_BYTES-1:0]     s_keep,
    input  logic                      s_last,
    output logic                      o_new,
    output logic                      o_last,
    output logic [8*BLK_BYTES-1:0]    o_plain_text,
    output logic [BLK_BYTES-1:0]      o_byte_mask,
    output logic [LEN_W-1:0]          o_len_bytes,
    output logic                      o_len_blk
);

    // The bare name GAP is the parameter; the FSM state is always package-qualified.
    pack_state_t                state, state_n;
    logic [1:0]                 idx;
    logic [8*BLK_BYTES-1:0]     hold;
    logic [LEN_W-1:0]           byte_cnt;
    logic [3:0]                 gap_cnt;
    logic                       last_q;
    logic                       len_pend;
    logic [8*BLK_BYTES-1:0]     plain_q;
    logic [BLK_BYTES-1:0]       mask_q;
    logic [LEN_W-1:0]           len_q;

    logic                       fire, close;
    logic [BEAT_BYTES-1:0]      keep_eff;
    logic [2:0]                 beat_cnt;
    logic [4:0]                 blk_fill;
    logic [BLK_BYTES-1:0]       fill_mask;
    logic [8*BLK_BYTES-1:0]     fill_expand;
    logic [8*BLK_BYTES-1:0]     merged;
    logic [LEN_W:0]             cnt_sum;
    logic [LEN_W-1:0]           cnt_next;
    logic [63:0]                bit_len;
    logic [8*BLK_BYTES-1:0]     len_text;

`ifdef GCM_PACK_LEN_BLOCK_EN
    localparam bit LEN_EN = 1'b1;
    assign o_len_blk = (state == LENB);
`else
    localparam bit LEN_EN = 1'b0;
    assign o_len_blk = 1'b0;
`endif

    assign s_ready      = (state == FILL) && !reset;
    assign fire         = s_valid && s_ready;
    assign close        = fire && ((idx == 2'd3) || s_last);
    assign keep_eff     = s_last ? s_keep : '1;
    assign beat_cnt     = keep_count(keep_eff);
    assign blk_fill     = {1'b0, idx, 2'b00} + {2'b00, beat_cnt};
    assign fill_mask    = byte_mask_from_count(blk_fill);
    assign cnt_sum      = {1'b0, byte_cnt} + (LEN_W+1)'(beat_cnt);
    assign cnt_next     = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];

    assign o_new        = (state == EMIT) || (state == LENB);
    assign o_last       = (state == EMIT) && last_q;
    assign o_plain_text = plain_q;
    assign o_byte_mask  = mask_q;
    assign o_len_bytes  = len_q;

    always_comb begin
        merged = hold;
        merged[{idx, 5'b00000} +: 8*BEAT_BYTES] = s_data;
        fill_expand = '0;
        for (int unsigned k = 0; k < BLK_BYTES; k++) begin
            fill_expand[8*k +: 8] = {8{fill_mask[k]}};
        end
    end

    // Length block: len(A)=0 in bytes 0..7, message bit length big-endian in bytes 8..15.
    always_comb begin
        bit_len = '0;
        bit_len[LEN_W-1:0] = len_q;
        bit_len = bit_len << 3;
        len_text = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            len_text[8*(8+j) +: 8] = bit_len[8*(7-j) +: 8];
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            FILL: if (close) state_n = EMIT;
            EMIT: begin
                if (GAP > 0)       state_n = aes_gcm_pkg::GAP;
                else if (len_pend) state_n = LENB;
                else               state_n = FILL;
            end
            aes_gcm_pkg::GAP: if (gap_cnt == '0) state_n = len_pend ? LENB : FILL;
            LENB: state_n = (GAP > 0) ? aes_gcm_pkg::GAP : FILL;
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state_n == aes_gcm_pkg::GAP && state != aes_gcm_pkg::GAP) begin
            gap_cnt <= 4'(GAP - 1);
        end else if (state == aes_gcm_pkg::GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold     <= '0;
            idx      <= '0;
            byte_cnt <= '0;
            plain_q  <= '0;
            mask_q   <= '0;
            last_q   <= 1'b0;
            len_q    <= '0;
            len_pend <= 1'b0;
        end else begin
            if (fire) begin
                hold     <= merged;
                idx      <= idx + 2'd1;
                byte_cnt <= cnt_next;
            end
            if (close) begin
                plain_q <= merged & fill_expand;
                mask_q  <= fill_mask;
                last_q  <= s_last;
                if (s_last) begin
                    len_q    <= cnt_next;
                    byte_cnt <= '0;
                    idx      <= '0;
                    len_pend <= LEN_EN;
                end
            end
            if (state_n == LENB && state != LENB) begin
                plain_q  <= len_text;
                mask_q   <= '1;
                last_q   <= 1'b0;
                len_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gcm_block_packer.sv
// Self-checking bench for gcm_block_packer against a byte-level message model.
// Honours GCM_PACK_LEN_BLOCK_EN the same way as the design.
module tb_gcm_block_packer;

    localparam int unsigned TB_GAP = 2;
`ifdef GCM_PACK_LEN_BLOCK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic [3:0]   s_keep;
    logic         s_last;
    logic         o_new;
    logic         o_last;
    logic [127:0] o_plain_text;
    logic [15:0]  o_byte_mask;
    logic [31:0]  o_len_bytes;
    logic         o_len_blk;

    gcm_block_packer #(.GAP(TB_GAP), .LEN_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_keep       (s_keep),
        .s_last       (s_last),
        .o_new        (o_new),
        .o_last       (o_last),
        .o_plain_text (o_plain_text),
        .o_byte_mask  (o_byte_mask),
        .o_len_bytes  (o_len_bytes),
        .o_len_blk    (o_len_blk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        logic [15:0]  m;
        logic         l;
        logic [31:0]  len;
        logic         lb;
        int unsigned  cyc;
    } blk_t;

    blk_t        blk_q[$];
    blk_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned last_hs = 0;
    int unsigned viol = 0;
    int unsigned last_new = 0;
    bit          seen_new = 1'b0;
    int unsigned checks = 0;
    int unsigned passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed pulses plus protocol violations (ready during EMIT/GAP, stray qualifiers).
    always @(negedge clk) begin
        blk_t r;
        if (o_new) begin
            r.pt = o_plain_text; r.m = o_byte_mask; r.l = o_last;
            r.len = o_len_bytes; r.lb = o_len_blk; r.cyc = cyc;
            blk_q.push_back(r);
            last_new = cyc;
            seen_new = 1'b1;
            if (s_ready) viol++;
        end else begin
            if (o_last || o_len_blk) viol++;
            if (s_ready && seen_new && !reset && (cyc - last_new) <= TB_GAP) viol++;
        end
    end

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input bit stall);
        int unsigned guard;
        if (stall && ($urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
        guard = 0;
        while (!s_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            checks++;
            $display("FAIL handshake_timeout: s_ready=%b after %0d cycles, required 1", s_ready, guard);
        end
        @(posedge clk);
        #1 last_hs = cyc;
    endtask

    // Drives one message and appends the model's expected blocks to exp_q.
    task automatic send_msg(input int unsigned nbeats, input logic [3:0] last_keep, input bit stall);
        logic [7:0]  msg[$];
        logic [31:0] d;
        logic [3:0]  k;
        logic [63:0] bits;
        blk_t        e;
        int unsigned nblk, idx;
        for (int unsigned b = 0; b < nbeats; b++) begin
            d = $urandom;
            k = (b == nbeats - 1) ? last_keep : 4'hF;
            for (int unsigned j = 0; j < 4; j++) if (k[j]) msg.push_back(d[8*j +: 8]);
            drive_beat(d, k, b == nbeats - 1, stall);
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        nblk = (nbeats + 3) / 4;
        for (int unsigned b = 0; b < nblk; b++) begin
            e.pt = '0; e.m = '0; e.lb = 1'b0; e.cyc = 0;
            for (int unsigned n = 0; n < 16; n++) begin
                idx = 16*b + n;
                if (idx < msg.size()) begin
                    e.pt[8*n +: 8] = msg[idx];
                    e.m[n] = 1'b1;
                end
            end
            e.l = (b == nblk - 1);
            e.len = msg.size();
            exp_q.push_back(e);
        end
        if (LEN_EN) begin
            bits = 64'(msg.size()) * 64'd8;
            e.pt = '0;
            for (int unsigned j = 0; j < 8; j++) e.pt[8*(8+j) +: 8] = 8'(bits >> (8*(7-j)));
            e.m = 16'hFFFF; e.l = 1'b0; e.lb = 1'b1; e.len = msg.size();
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; s_data = 32'hA5A5A5A5; s_keep = 4'hF; s_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0) $display("FAIL reset_ready: s_ready=%b required 0", s_ready);
            else passed++;
            checks++;
            if (o_new !== 1'b0) $display("FAIL reset_new: o_new=%b required 0", o_new);
            else passed++;
        end
        checks++;
        if ({o_last, o_len_blk, o_byte_mask, o_len_bytes, o_plain_text} !== '0)
            $display("FAIL reset_outputs: last=%b lenblk=%b mask=%h len=%0d pt=%h required all 0",
                     o_last, o_len_blk, o_byte_mask, o_len_bytes, o_plain_text);
        else passed++;
        reset = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) $display("FAIL reset_release_ready: s_ready=%b required 1", s_ready);
        else passed++;
    endtask

    task automatic test_nist_block();
        logic [31:0] beats[4] = '{32'h253231D9, 32'hE50684F8, 32'hC50959A5, 32'h9A26F5AF};
        blk_q.delete();
        for (int i = 0; i < 4; i++) drive_beat(beats[i], 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (o_new !== 1'b1 || o_plain_text !== 128'h9A26F5AFC50959A5E50684F8253231D9 ||
            o_byte_mask !== 16'hFFFF || o_last !== 1'b0)
            $display("FAIL nist_block: new=%b pt=%h mask=%h last=%b required 1/9a26f5afc50959a5e50684f8253231d9/ffff/0",
                     o_new, o_plain_text, o_byte_mask, o_last);
        else passed++;
        // Closing the message with an empty keep on an empty block.
        drive_beat(32'hDEADBEEF, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        checks++;
        if (o_new !== 1'b1 || o_last !== 1'b1 || o_byte_mask !== 16'h0000 ||
            o_plain_text !== '0 || o_len_bytes !== 32'd16)
            $display("FAIL keep0_empty_block: new=%b last=%b mask=%h pt=%h len=%0d required 1/1/0000/0/16",
                     o_new, o_last, o_byte_mask, o_plain_text, o_len_bytes);
        else passed++;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_messages();
        logic [3:0] keeps[5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
        int unsigned nb[7];
        logic [3:0]  kp[7];
        nb[0] = 15; kp[0] = 4'hF;
        nb[1] = 2;  kp[1] = 4'b0011;
        for (int i = 2; i < 7; i++) begin
            nb[i] = $urandom_range(1, 12);
            kp[i] = keeps[$urandom_range(0, 4)];
        end
        for (int t = 0; t < 7; t++) begin
            blk_q.delete(); exp_q.delete();
            send_msg(nb[t], kp[t], t >= 2);
            repeat (16) @(negedge clk);
            checks++;
            if (blk_q.size() !== exp_q.size())
                $display("FAIL msg%0d_count: pulses=%0d required %0d", t, blk_q.size(), exp_q.size());
            else passed++;
            for (int i = 0; i < exp_q.size() && i < blk_q.size(); i++) begin
                checks++;
                if (blk_q[i].pt !== exp_q[i].pt || blk_q[i].m !== exp_q[i].m ||
                    blk_q[i].l !== exp_q[i].l || blk_q[i].lb !== exp_q[i].lb)
                    $display("FAIL msg%0d_blk%0d: pt=%h mask=%h last=%b lenblk=%b required pt=%h mask=%h last=%b lenblk=%b",
                             t, i, blk_q[i].pt, blk_q[i].m, blk_q[i].l, blk_q[i].lb,
                             exp_q[i].pt, exp_q[i].m, exp_q[i].l, exp_q[i].lb);
                else passed++;
                if (exp_q[i].l) begin
                    checks++;
                    if (blk_q[i].len !== exp_q[i].len || blk_q[i].cyc !== last_hs)
                        $display("FAIL msg%0d_last: len=%0d cycle=%0d required len=%0d cycle=%0d",
                                 t, blk_q[i].len, blk_q[i].cyc, exp_q[i].len, last_hs);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned gap;
        blk_q.delete(); exp_q.delete();
        viol = 0;
        send_msg(8, 4'hF, 1'b0);
        send_msg(4, 4'hF, 1'b0);
        repeat (16) @(negedge clk);
        checks++;
        if (blk_q.size() !== exp_q.size())
            $display("FAIL b2b_count: pulses=%0d required %0d", blk_q.size(), exp_q.size());
        else passed++;
        checks++;
        if (viol !== 0) $display("FAIL b2b_protocol: violations=%0d required 0", viol);
        else passed++;
        for (int i = 1; i < blk_q.size(); i++) begin
            gap = blk_q[i].cyc - blk_q[i-1].cyc;
            if (!blk_q[i].lb && !blk_q[i-1].lb) begin
                checks++;
                if (gap < 5 + TB_GAP) $display("FAIL b2b_spacing%0d: spacing=%0d required >=%0d", i, gap, 5 + TB_GAP);
                else passed++;
            end
        end
        for (int i = 0; i < exp_q.size() && i < blk_q.size(); i++) begin
            if (exp_q[i].l) begin
                checks++;
                if (blk_q[i].len !== exp_q[i].len || blk_q[i].pt !== exp_q[i].pt || blk_q[i].l !== 1'b1)
                    $display("FAIL b2b_last%0d: len=%0d last=%b pt=%h required len=%0d last=1 pt=%h",
                             i, blk_q[i].len, blk_q[i].l, blk_q[i].pt, exp_q[i].len, exp_q[i].pt);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_block();
        blk_q.delete(); exp_q.delete();
        drive_beat($urandom, 4'hF, 1'b0, 1'b0);
        drive_beat($urandom, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (blk_q.size() !== 0) $display("FAIL midreset_no_pulse: pulses=%0d required 0", blk_q.size());
        else passed++;
        reset = 1'b0;
        send_msg(4, 4'hF, 1'b0);
        repeat (16) @(negedge clk);
        checks++;
        if (blk_q.size() !== exp_q.size())
            $display("FAIL midreset_count: pulses=%0d required %0d", blk_q.size(), exp_q.size());
        else passed++;
        if (blk_q.size() > 0) begin
            checks++;
            if (blk_q[0].pt !== exp_q[0].pt || blk_q[0].m !== 16'hFFFF || blk_q[0].l !== 1'b1 || blk_q[0].len !== 32'd16)
                $display("FAIL midreset_block: pt=%h mask=%h last=%b len=%0d required pt=%h mask=ffff last=1 len=16",
                         blk_q[0].pt, blk_q[0].m, blk_q[0].l, blk_q[0].len, exp_q[0].pt);
            else passed++;
        end
    endtask

    task automatic test_len_block();
        int unsigned nlb;
        blk_q.delete(); exp_q.delete();
        send_msg(16, 4'hF, 1'b1);
        repeat (16) @(negedge clk);
        nlb = 0;
        foreach (blk_q[i]) if (blk_q[i].lb) nlb++;
        checks++;
        if (blk_q.size() !== exp_q.size())
            $display("FAIL lenblk_count: pulses=%0d required %0d", blk_q.size(), exp_q.size());
        else passed++;
        checks++;
        if (nlb !== int'(LEN_EN)) $display("FAIL lenblk_pulses: len_blk pulses=%0d required %0d", nlb, int'(LEN_EN));
        else passed++;
        if (blk_q.size() > 0 && exp_q.size() > 0) begin
            checks++;
            if (blk_q[$].pt !== exp_q[$].pt || blk_q[$].m !== exp_q[$].m ||
                blk_q[$].l !== exp_q[$].l || blk_q[$].lb !== exp_q[$].lb)
                $display("FAIL lenblk_final: pt=%h mask=%h last=%b lenblk=%b required pt=%h mask=%h last=%b lenblk=%b",
                         blk_q[$].pt, blk_q[$].m, blk_q[$].l, blk_q[$].lb,
                         exp_q[$].pt, exp_q[$].m, exp_q[$].l, exp_q[$].lb);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_nist_block();
        test_messages();
        test_back_to_back();
        test_reset_mid_block();
        test_len_block();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/gcm_block_packer.md
Name: gcm_block_packer

Overview:
- Upstream feeder for aes_api.
- Accepts a 32-bit valid/ready byte stream and packs it into 128-bit plaintext blocks in the byte order aes_api consumes (first message byte at bit [7:0]).
- Zero-pads the final partial block and drives aes_api's i_new / i_last / i_plain_text.
- Enforces the minimum spacing between i_new pulses that aes_api requires.

Parameters:
- GAP, 1: idle cycles inserted after each o_new pulse before the next beat is accepted (0..15).
- LEN_W, 32: width of the message byte counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  packer can accept a beat.
- s_data  in  32  input bytes; stream byte order is s_data[7:0] first, s_data[31:24] last.
- s_keep  in  4  byte enables; honoured only on the s_last beat, where they must be contiguous from bit 0.
- s_last  in  1  final beat of the message.
- o_new  out  1  one-cycle pulse: block valid (to aes_api i_new).
- o_last  out  1  qualifies o_new: final block of the message (to i_last).
- o_plain_text  out  128  packed block (to i_plain_text); message byte k of the block is at [8k+7:8k].
- o_byte_mask  out  16  bit k set when block byte k carries message data.
- o_len_bytes  out  LEN_W  total message bytes; valid while o_last=1.
- o_len_blk  out  1  qualifies o_new: length block (see Optional Feature; otherwise 0).

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0 (o_new, o_last, o_plain_text, o_byte_mask, o_len_bytes, o_len_blk); s_ready=0 during reset.
  - FSM goes to FILL; lane index, byte counter and gap counter cleared.
  - Reset mid-block discards the partial block; no o_new is issued for it.
- FSM states:
  - FILL: s_ready=1. On s_valid&s_ready, the beat is written to lane idx (0..3) of the holding register.
    - On a non-last beat, s_keep is ignored and treated as 4'hF.
    - Go to EMIT when idx==3 or s_last.
  - EMIT (one cycle): s_ready=0.
    - o_new=1; o_plain_text / o_byte_mask loaded from the holding register, with unfilled bytes forced to 8'h00.
    - o_last=1 if the block closed on s_last, and o_len_bytes is then updated.
    - Next state is GAP if GAP>0, else FILL.
    - Byte counter and lane index clear after a last block.
  - GAP: s_ready=0 for GAP cycles, then FILL.
- Latency: o_new is asserted in the cycle after the handshake of the closing beat.
- Output holding: o_plain_text, o_byte_mask, o_last and o_len_bytes hold their values until the next o_new. o_new and o_last are never high outside EMIT.
- Byte counter: adds popcount(keep) per beat and saturates at 2^LEN_W-1.
- Last beat with s_keep=0:
  - Still closes the message.
  - If the current block is empty, a block with mask 16'h0000 and data zeros is emitted with o_last=1.
- Throughput per full block: 4 + 1 + GAP cycles.
- Downstream (aes_api) has no backpressure; the packer assumes every o_new is taken.

Optional Feature:
- Macro: GCM_PACK_LEN_BLOCK_EN.
- Defined:
  - After the o_last block's EMIT (and its GAP), an additional EMIT cycle issues the GHASH length block, followed by its own GAP.
  - Length block signals: o_new=1, o_len_blk=1, o_last=0, o_byte_mask=16'hFFFF.
  - Block contents: bytes 0..7 = 0 (len(A)); bytes 8..15 = 64-bit message bit length (o_len_bytes*8) big-endian, byte 8 most significant.
- Undefined: the length block is never emitted and o_len_blk is tied to 0.

Decomposition:
- Package aes_gcm_pkg holds:
  - BLK_BYTES=16, BEAT_BYTES=4 constants.
  - FSM enum pack_state_t {FILL, EMIT, GAP, LENB}.
  - Function byte_mask_from_count().
- No sub-module. The holding register, lane mux and counters are small enough to sit in one module.

Test Plan:
- Reset: hold reset 3 cycles with s_valid=1 -> s_ready=0 and o_new=0 throughout; s_ready=1 the cycle after reset drops.
- NIST GCM Ex.4 first block: beats 32'h253231D9, 32'hE50684F8, 32'hC50959A5, 32'h9A26F5AF, last=0 -> one cycle after the 4th handshake, o_new=1, o_plain_text=128'h9A26F5AFC50959A5E50684F8253231D9, o_byte_mask=16'hFFFF, o_last=0.
- 60-byte message (15 full beats, last on beat 15) -> 4 o_new pulses; the 4th has o_last=1, o_byte_mask=16'h0FFF, bytes 12..15 = 0, o_len_bytes=60.
- 6-byte message (beat 1 full, beat 2 s_last with s_keep=4'b0011) -> one o_new, o_last=1, o_byte_mask=16'h003F, o_len_bytes=6.
- GAP=2 with two back-to-back messages:
  - o_new pulses are at least 7 cycles apart within a block stream.
  - s_ready=0 in every EMIT and GAP cycle.
  - The second message's o_len_bytes counts only its own bytes.
- Reset asserted after 2 accepted beats, then a fresh 16-byte message -> no o_new before the reset; exactly one block afterwards, containing only new data, with o_last=1.
- With GCM_PACK_LEN_BLOCK_EN, 64-byte message -> 5 pulses.
  - The 5th pulse has o_len_blk=1 and o_plain_text=128'h0002_0000_0000_0000_0000_0000_0000_0000 (bit length 512: byte 14=8'h02, byte 15=8'h00).
  - Without the macro, only 4 pulses and o_len_blk stays 0.
